// File: rtl/extmem_responder.sv
// On-chip stand-in for the layer controller's external memory: fixed-latency reads,
// optional post-reset zero fill, sticky error flags and saturating access counters.
module extmem_responder #(
    parameter int DATA_W         = 16,
    parameter int ADDR_W         = 20,
    parameter int DEPTH          = 65536,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              re,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_valid,
    output logic              ready,
    input  logic              err_clr,
    output logic              err_oob,
    output logic              err_busy,
    output logic [31:0]       wr_count,
    output logic [31:0]       rd_count
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   DEPTH_A = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_A  = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;
    logic              clr_active;

    logic [DATA_W-1:0] mem [DEPTH];

    logic              wr_in_rng, rd_in_rng;
    logic              wr_fire, rd_take, rd_fire;
    logic              mem_we;
    logic [IDX_W-1:0]  mem_widx;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] rd_word;

    logic [DATA_W-1:0] pipe_data_q [RD_LAT];
    logic [DATA_W-1:0] pipe_data_d [RD_LAT];
    logic [RD_LAT-1:0] pipe_vld_q, pipe_vld_d;

    logic              err_oob_q, err_oob_d;
    logic              err_busy_q, err_busy_d;
    logic [31:0]       wr_count_q, wr_count_d;
    logic [31:0]       rd_count_q, rd_count_d;

    assign ready = (state_q == ST_RUN);

    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_active = 1'b0;
        case (state_q)
            ST_INIT: begin
                if (CLEAR_ON_RESET != 0) begin
                    clr_active = 1'b1;
                    clr_addr_d = clr_addr_q + 1'b1;
                    if (clr_addr_q == LAST_A) begin
                        state_d    = ST_RUN;
                        clr_addr_d = '0;
                    end
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_INIT;
        endcase
    end

    always_comb begin
        wr_in_rng = {1'b0, wr_addr} < DEPTH_A;
        rd_in_rng = {1'b0, rd_addr} < DEPTH_A;
        wr_fire   = ready & we & wr_in_rng;
        // Out-of-range reads still return a (zero) word so the requester never stalls.
        rd_take   = ready & re;
        rd_fire   = rd_take & rd_in_rng;

        mem_we    = clr_active | wr_fire;
        mem_widx  = clr_active ? IDX_W'(clr_addr_q) : IDX_W'(wr_addr);
        mem_wdata = clr_active ? '0 : wr_data;
        rd_word   = rd_in_rng ? mem[IDX_W'(rd_addr)] : '0;
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_widx] <= mem_wdata;
        end
    end

    // Each stage only takes new data behind a valid, so the last stage holds the last word returned.
    always_comb begin
        pipe_vld_d[0]  = rd_take;
        pipe_data_d[0] = rd_take ? rd_word : pipe_data_q[0];
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_vld_d[i]  = pipe_vld_q[i-1];
            pipe_data_d[i] = pipe_vld_q[i-1] ? pipe_data_q[i-1] : pipe_data_q[i];
        end
    end

    always_comb begin
        err_oob_d  = (ready & ((we & ~wr_in_rng) | (re & ~rd_in_rng)))
                   | (err_oob_q & ~err_clr);
        err_busy_d = (~ready & (we | re)) | (err_busy_q & ~err_clr);
        wr_count_d = (wr_fire && (wr_count_q != 32'hFFFF_FFFF)) ? wr_count_q + 32'd1 : wr_count_q;
        rd_count_d = (rd_fire && (rd_count_q != 32'hFFFF_FFFF)) ? rd_count_q + 32'd1 : rd_count_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_INIT;
            clr_addr_q <= '0;
            pipe_vld_q <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_q[i] <= '0;
            end
            err_oob_q  <= 1'b0;
            err_busy_q <= 1'b0;
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            pipe_vld_q <= pipe_vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_data_q[i] <= pipe_data_d[i];
            end
            err_oob_q  <= err_oob_d;
            err_busy_q <= err_busy_d;
            wr_count_q <= wr_count_d;
            rd_count_q <= rd_count_d;
        end
    end

    assign rd_data  = pipe_data_q[RD_LAT-1];
    assign rd_valid = pipe_vld_q[RD_LAT-1];
    assign err_oob  = err_oob_q;
    assign err_busy = err_busy_q;
    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;

endmodule

// File: tb/tb_extmem_responder.sv
// Randomized bench for extmem_responder: two instances (read latency 1 and 3) share
// stimulus and are compared every cycle against a queue-based memory model.
module tb_extmem_responder;

    localparam int DW  = 16;
    localparam int AW  = 20;
    localparam int DEP = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          we, re, err_clr;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;

    logic [DW-1:0] rd_data1, rd_data3;
    logic          rd_valid1, rd_valid3, ready1, ready3;
    logic          err_oob1, err_oob3, err_busy1, err_busy3;
    logic [31:0]   wr_count1, wr_count3, rd_count1, rd_count3;

    always #5 clk = ~clk;

    extmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(1), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .re(re), .rd_addr(rd_addr), .rd_data(rd_data1), .rd_valid(rd_valid1),
        .ready(ready1), .err_clr(err_clr), .err_oob(err_oob1), .err_busy(err_busy1),
        .wr_count(wr_count1), .rd_count(rd_count1)
    );

    extmem_responder #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .RD_LAT(3), .CLEAR_ON_RESET(1)) dut3 (
        .clk(clk), .rst(rst), .we(we), .wr_addr(wr_addr), .wr_data(wr_data),
        .re(re), .rd_addr(rd_addr), .rd_data(rd_data3), .rd_valid(rd_valid3),
        .ready(ready3), .err_clr(err_clr), .err_oob(err_oob3), .err_busy(err_busy3),
        .wr_count(wr_count3), .rd_count(rd_count3)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model
    typedef struct {
        int          due;
        logic [15:0] d;
    } ret_t;

    logic [15:0] m_mem [DEP];
    bit          m_ready, m_oob, m_busy;
    int          m_init, cyc;
    logic [31:0] m_wcnt, m_rcnt;
    ret_t        q1[$], q3[$];
    bit          e_vld1, e_vld3;
    logic [15:0] e_dat1, e_dat3;

    task automatic model_reset();
        m_ready = 0; m_init = 0; m_oob = 0; m_busy = 0;
        m_wcnt = '0; m_rcnt = '0;
        q1.delete(); q3.delete();
        e_vld1 = 0; e_vld3 = 0; e_dat1 = '0; e_dat3 = '0;
    endtask

    task automatic model_edge();
        bit          busy_e, oob_e;
        logic [15:0] d;
        ret_t        r;
        cyc++;
        busy_e = !m_ready && (we || re);
        oob_e  = m_ready && ((we && wr_addr >= DEP) || (re && rd_addr >= DEP));
        if (m_ready && re) begin
            d = (rd_addr < DEP) ? m_mem[rd_addr[3:0]] : 16'h0000;
            r.d = d;
            r.due = cyc;     q1.push_back(r);
            r.due = cyc + 2; q3.push_back(r);
            if (rd_addr < DEP && m_rcnt != 32'hFFFF_FFFF) m_rcnt = m_rcnt + 1;
        end
        if (m_ready && we && wr_addr < DEP) begin
            m_mem[wr_addr[3:0]] = wr_data;
            if (m_wcnt != 32'hFFFF_FFFF) m_wcnt = m_wcnt + 1;
        end
        if (!m_ready) begin
            m_mem[m_init[3:0]] = 16'h0000;
            m_init++;
            if (m_init == DEP) m_ready = 1;
        end
        m_oob  = oob_e  || (m_oob  && !err_clr);
        m_busy = busy_e || (m_busy && !err_clr);
        e_vld1 = 0;
        if (q1.size() > 0 && q1[0].due == cyc) begin
            e_vld1 = 1; e_dat1 = q1[0].d; void'(q1.pop_front());
        end
        e_vld3 = 0;
        if (q3.size() > 0 && q3[0].due == cyc) begin
            e_vld3 = 1; e_dat3 = q3[0].d; void'(q3.pop_front());
        end
    endtask

    task automatic check_all();
        chk("ready",     32'(ready1),    32'(m_ready));
        chk("rd_valid",  32'(rd_valid1), 32'(e_vld1));
        chk("rd_data",   32'(rd_data1),  32'(e_dat1));
        chk("err_oob",   32'(err_oob1),  32'(m_oob));
        chk("err_busy",  32'(err_busy1), 32'(m_busy));
        chk("wr_count",  wr_count1,      m_wcnt);
        chk("rd_count",  rd_count1,      m_rcnt);
        chk("ready3",    32'(ready3),    32'(m_ready));
        chk("rd_valid3", 32'(rd_valid3), 32'(e_vld3));
        chk("rd_data3",  32'(rd_data3),  32'(e_dat3));
        chk("wr_count3", wr_count3,      m_wcnt);
        chk("rd_count3", rd_count3,      m_rcnt);
    endtask

    task automatic set_in(input bit w, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                          input bit r, input logic [AW-1:0] ra, input bit c);
        we = w; wr_addr = wa; wr_data = wd; re = r; rd_addr = ra; err_clr = c;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            set_in(0, '0, '0, 0, '0, 0);
            tick();
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (!rst) model_edge();
        #1;
        check_all();
        @(negedge clk);
    endtask

    task automatic async_reset();
        rst = 1'b1;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [AW-1:0] rand_addr();
        if ($urandom_range(0, 9) == 0) return AW'($urandom);
        return AW'($urandom_range(0, 19));
    endfunction

    initial begin
        cyc = 0;
        rst = 1'b1;
        set_in(0, '0, '0, 0, '0, 0);
        model_reset();
        repeat (2) @(negedge clk);
        check_all();
        rst = 1'b0;

        // INIT: accesses are dropped and flag err_busy; ready after 16 edges
        for (int i = 0; i < DEP; i++) begin
            set_in(i == 3, 20'd2, 16'h1111, (i == 3) || (i == 5), 20'd1, 0);
            tick();
        end
        set_in(0, '0, '0, 0, '0, 1);
        tick();

        // Cleared array reads back zero, back-to-back
        for (int i = 0; i < DEP; i++) begin
            set_in(0, '0, '0, 1, AW'(i), 0);
            tick();
        end
        idle(3);

        set_in(1, 20'd3, 16'hA5A5, 0, '0, 0); tick();
        set_in(1, 20'd4, 16'h1234, 0, '0, 0); tick();
        set_in(0, '0, '0, 1, 20'd3, 0); tick();
        set_in(0, '0, '0, 1, 20'd4, 0); tick();
        idle(3);

        // Read-before-write on the same address
        set_in(1, 20'd5, 16'hBEEF, 1, 20'd5, 0); tick();
        set_in(0, '0, '0, 1, 20'd5, 0); tick();
        idle(3);

        // Out of range, clear, then clear colliding with a new error
        set_in(1, 20'd20, 16'h7777, 1, 20'd20, 0); tick();
        idle(3);
        set_in(0, '0, '0, 0, '0, 1); tick();
        set_in(1, 20'd20, 16'h7777, 0, '0, 0); tick();
        set_in(0, '0, '0, 1, 20'hFFFFF, 1); tick();
        set_in(0, '0, '0, 0, '0, 1); tick();
        idle(3);

        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom), rand_addr(), DW'($urandom), 1'($urandom), rand_addr(),
                   $urandom_range(0, 15) == 0);
            tick();
        end

        // Reset with reads in flight, then abort a clear at address 7
        set_in(0, '0, '0, 1, 20'd3, 0);
        async_reset();
        for (int i = 0; i < 7; i++) begin
            set_in(0, '0, '0, 0, '0, 0);
            tick();
        end
        async_reset();
        idle(DEP);

        for (int i = 0; i < 40; i++) begin
            set_in(1'($urandom), rand_addr(), DW'($urandom), 1'($urandom), rand_addr(), 0);
            tick();
        end

        // Saturation of the write counter
        force dut.wr_count_q  = 32'hFFFF_FFFF;
        force dut3.wr_count_q = 32'hFFFF_FFFF;
        #1;
        release dut.wr_count_q;
        release dut3.wr_count_q;
        m_wcnt = 32'hFFFF_FFFF;
        set_in(1, 20'd6, 16'h0606, 0, '0, 0); tick();
        set_in(1, 20'd7, 16'h0707, 1, 20'd6, 0); tick();
        set_in(1, 20'd8, 16'h0808, 1, 20'd7, 0); tick();
        idle(3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/extmem_responder.md
Name: extmem_responder

Overview:
- Memory-side responder for the external-memory interface driven by the layer controller.
- The controller issues re/rd_addr for buffer loads and we/wr_addr/wr_data for buffer saves; this block services both.
- Provides a synthesizable on-chip model of the external memory with fixed read latency, post-reset clear sequence, error flags and access counters.
- Used as the extmem endpoint in top-level simulation and FPGA builds.

Parameters:
- DATA_W, 16, data word width (matches buffer word).
- ADDR_W, 20, address port width.
- DEPTH, 65536, number of implemented words; DEPTH <= 2**ADDR_W; need not be a power of two.
- RD_LAT, 1, read latency in cycles from re sample to rd_data/rd_valid; legal range 1..4.
- CLEAR_ON_RESET, 1, 1 = zero the whole array after reset before accepting accesses.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- we  in  1  write request, sampled every posedge
- wr_addr  in  ADDR_W  write word address
- wr_data  in  DATA_W  write data
- re  in  1  read request, sampled every posedge
- rd_addr  in  ADDR_W  read word address
- rd_data  out  DATA_W  read data; holds last value between reads
- rd_valid  out  1  one-cycle pulse per returned read word
- ready  out  1  high when accesses are accepted (RUN state)
- err_clr  in  1  synchronous clear of sticky error flags
- err_oob  out  1  sticky: access to address >= DEPTH
- err_busy  out  1  sticky: access attempted while not ready
- wr_count  out  32  accepted in-range writes, saturating
- rd_count  out  32  accepted in-range reads, saturating

Behaviour:
- Reset: rst is asynchronous and active-high; clock is clk.
- Output values during reset: rd_data=0, rd_valid=0, ready=0, err_oob=0, err_busy=0, wr_count=0, rd_count=0. The read pipeline is flushed; any in-flight read is discarded with no rd_valid.
- Array contents are not reset by rst. With CLEAR_ON_RESET=0, contents are retained.
- FSM has two states, INIT and RUN.
- INIT (entered on reset when CLEAR_ON_RESET=1):
  - A clear counter writes 0 to addresses 0..DEPTH-1, one per cycle, starting at the first posedge after rst deasserts.
  - After the write to DEPTH-1, go to RUN; ready=1 from the next cycle. Total time is DEPTH cycles from the first edge.
  - we/re in INIT are dropped and set err_busy. Reads produce no rd_valid. Counters are unchanged.
- With CLEAR_ON_RESET=0 the FSM leaves reset directly in RUN; ready=1 at the first posedge after deassert.
- RUN write: if we=1 and wr_addr<DEPTH, the array is written at that edge and wr_count increments.
- RUN read: if re=1 and rd_addr<DEPTH, the array is read at the sample edge. rd_data and rd_valid appear RD_LAT cycles later.
  - RD_LAT=1: data is visible in the cycle after re.
  - Back-to-back reads (re held high) return one word per cycle, in order, with no bubbles.
  - rd_count increments at the sample edge.
- Same-cycle read and write to the same address: read-before-write; the read returns the old data. A write landing while a read is in the pipeline does not alter that read's data.
- Out-of-range access (addr >= DEPTH, including addresses truncated at ADDR_W):
  - Writes are dropped.
  - Reads return rd_data=0 with a normal rd_valid pulse at RD_LAT.
  - err_oob is set. Counters do not increment.
- Error flags are sticky until err_clr=1. If err_clr and a new error occur in the same cycle, the flag ends set (error wins).
- Counters saturate at 32'hFFFF_FFFF and do not wrap.
- Simultaneous valid we and re to different addresses are both serviced in the same cycle.
- Reset asserted mid-operation: an INIT clear in progress aborts and restarts from address 0 after deassert. The pipeline is flushed and all flags and counters return to 0.

Test Plan:
- Reset with CLEAR_ON_RESET=1, DEPTH=16 -> ready rises 16 cycles after rst deassert; then 16 reads return 0x0000 with rd_valid.
- RUN, write 0xA5A5 @3 and 0x1234 @4, then re held high over addr 3,4 with RD_LAT=1 -> rd_data 0xA5A5 then 0x1234 on consecutive cycles with rd_valid; wr_count=2, rd_count=2.
- Same cycle: we @5 data 0xBEEF, re @5 (old value 0x0000) -> returns 0x0000; a read the next cycle returns 0xBEEF.
- DEPTH=16, write @20 and read @20 -> no array change, rd_data=0 with rd_valid, err_oob=1, counters unchanged; err_clr -> err_oob=0.
- re pulse during INIT -> no rd_valid, err_busy=1. rst asserted at clear address 7 -> after deassert, INIT restarts from 0 and takes the full 16 cycles.
- RD_LAT=3, burst of 4 reads -> rd_valid pulses 3 cycles after each re, in order. Preloading wr_count to 0xFFFF_FFFF and then writing -> wr_count stays at 0xFFFF_FFFF.
